// File: rtl/fft_input_framer.sv
// Captures one N-sample frame into an on-chip buffer, then streams it out as AXI-Stream FFT input words.
// Define FFT_FRAMER_AUTO_REARM_EN to re-enter capture directly after each frame (continuous framing).
module fft_input_framer #(
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned FRAME_LOG2 = 10
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic              start,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic              start_ignored
);

    localparam int unsigned FRAME_N = 1 << FRAME_LOG2;
    localparam int unsigned REAL_W  = 16;
    localparam logic [FRAME_LOG2-1:0] LAST_ADDR = FRAME_LOG2'(FRAME_N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_W-1:0]       mem [FRAME_N];
    logic [FRAME_LOG2-1:0]   wr_addr;
    logic [FRAME_LOG2-1:0]   rd_addr;
    logic                    rd_done;
    logic                    rd_pending;
    logic                    rd_last;
    logic [DATA_W-1:0]       rd_data;
    logic [REAL_W-1:0]       rd_real;
    logic                    skid_valid;
    logic                    skid_last;
    logic [REAL_W-1:0]       skid_real;
    logic                    wr_en;
    logic                    issue;
    logic                    pop;
    logic                    frame_end;
    logic                    load_out;
    logic [1:0]              occ_after;

    assign rd_real  = REAL_W'($signed(rd_data));
    assign load_out = pop || !m_tvalid;

    // Next-state and datapath strobes; reads are throttled so that output + skid + in-flight never exceeds two
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        issue      = 1'b0;
        frame_end  = 1'b0;
        pop        = m_tvalid && m_tready;
        occ_after  = 2'(m_tvalid) + 2'(skid_valid) + 2'(rd_pending) - 2'(pop);
        case (state)
            IDLE: begin
                if (start) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (data_in_valid) begin
                    wr_en = 1'b1;
                    if (wr_addr == LAST_ADDR) state_next = DRAIN;
                end
            end
            DRAIN: begin
                issue = !rd_done && (occ_after < 2'd2);
                if (pop && m_tlast) begin
                    frame_end = 1'b1;
`ifdef FFT_FRAMER_AUTO_REARM_EN
                    state_next = CAPTURE;
`else
                    state_next = IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Sample buffer: contents are never reset, only read back after being written this frame
    always_ff @(posedge sclk) begin
        if (wr_en) mem[wr_addr] <= data_in;
        if (issue) rd_data <= mem[rd_addr];
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            start_ignored <= 1'b0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            rd_done       <= 1'b0;
            rd_pending    <= 1'b0;
            rd_last       <= 1'b0;
        end else begin
            busy          <= (state_next != IDLE);
            frame_done    <= frame_end;
            start_ignored <= start && (state != IDLE);
            rd_pending    <= issue;
            rd_last       <= issue && (rd_addr == LAST_ADDR);
            if (wr_en)              wr_addr <= wr_addr + 1'b1;
            else if (state == IDLE) wr_addr <= '0;
            if (frame_end) begin
                rd_addr <= '0;
                rd_done <= 1'b0;
            end else if (issue) begin
                rd_addr <= rd_addr + 1'b1;
                if (rd_addr == LAST_ADDR) rd_done <= 1'b1;
            end
        end
    end

    // Output register backed by a one-entry skid that absorbs the RAM read latency during stalls
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata    <= '0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_real  <= '0;
        end else if (frame_end) begin
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
        end else if (load_out) begin
            if (skid_valid) begin
                m_tdata    <= {16'd0, skid_real};
                m_tlast    <= skid_last;
                m_tvalid   <= 1'b1;
                skid_valid <= rd_pending;
                if (rd_pending) begin
                    skid_real <= rd_real;
                    skid_last <= rd_last;
                end
            end else if (rd_pending) begin
                m_tdata  <= {16'd0, rd_real};
                m_tlast  <= rd_last;
                m_tvalid <= 1'b1;
            end else begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
        end else if (rd_pending) begin
            skid_valid <= 1'b1;
            skid_real  <= rd_real;
            skid_last  <= rd_last;
        end
    end

endmodule

// File: tb/tb_fft_input_framer.sv
// Scoreboard bench for fft_input_framer: expected words queued as samples are captured, compared on each output handshake.
module tb_fft_input_framer;

    localparam int unsigned DATA_W  = 14;
    localparam int unsigned FRAME_N = 1024;
    localparam int          RAMP    = 0;
    localparam int          EXTREME = 1;

    logic              sclk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] data_in;
    logic              data_in_valid;
    logic              start;
    logic [31:0]       m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              busy;
    logic              frame_done;
    logic              start_ignored;

    int          total = 0;
    int          bad   = 0;
    logic [32:0] exp_q[$];
    logic [31:0] got_words[FRAME_N];
    int          widx = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          done_cnt = 0;
    int          ign_cnt = 0;
    bit          rand_ready = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    fft_input_framer #(.DATA_W(DATA_W), .FRAME_LOG2(10)) dut (
        .sclk          (sclk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .start         (start),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast),
        .busy          (busy),
        .frame_done    (frame_done),
        .start_ignored (start_ignored)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [DATA_W-1:0] d);
        return {16'h0000, {2{d[DATA_W-1]}}, d};
    endfunction

    function automatic logic [DATA_W-1:0] gen_sample(input int kind, input int n);
        if (kind == EXTREME) begin
            if (n == 0) return 14'h2000;
            if (n == 1) return 14'h1FFF;
            return DATA_W'($urandom);
        end
        return DATA_W'(n % 8192);
    endfunction

    // Output monitor: scoreboard compare, stall stability, burst-rate and pulse counting
    always @(negedge sclk) begin
        logic [32:0] e;
        cyc++;
        if (!rst_n) begin
            stall_prev = 1'b0;
            widx       = 0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", {31'd0, m_tvalid}, 32'd1);
                check("hold_data", m_tdata, prev_data);
                check("hold_last", {31'd0, m_tlast}, {31'd0, prev_last});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", {31'd0, m_tvalid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", m_tdata, e[31:0]);
                    check("last", {31'd0, m_tlast}, {31'd0, e[32]});
                    if (widx == 0) t0 = cyc;
                    if (widx < FRAME_N) got_words[widx] = m_tdata;
                    widx++;
                    if (e[32]) begin
                        if (!rand_ready) check("burst_cycles", 32'(cyc - t0), 32'd1023);
                        widx = 0;
                    end
                end
            end
            stall_prev = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (frame_done)    done_cnt++;
            if (start_ignored) ign_cnt++;
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge sclk);
            #1 m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Junk samples around the start pulse must be discarded; samples are queued only while capturing
    task automatic send_frame(input int period, input int kind, input bit mid_start);
        int n = 0;
        int c = 0;
        data_in_valid = 1'b1;
        data_in       = DATA_W'($urandom);
        @(posedge sclk);
        #1 start = 1'b1;
        data_in = DATA_W'($urandom);
        @(posedge sclk);
        #1 start = 1'b0;
        while (n < FRAME_N) begin
            start         = 1'b0;
            data_in_valid = ((c % period) == 0);
            if (data_in_valid) begin
                data_in = gen_sample(kind, n);
                exp_q.push_back({(n == FRAME_N - 1), exp_word(data_in)});
                if (mid_start && n == 500) start = 1'b1;
                n++;
            end else begin
                data_in = DATA_W'($urandom);
            end
            @(posedge sclk);
            #1 c++;
        end
        start         = 1'b0;
        data_in_valid = 1'b1;
        data_in       = DATA_W'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < 20000) begin
            @(posedge sclk);
            k++;
        end
        if (done_cnt == d0) check({tag, "_timeout"}, 32'(done_cnt), 32'(d0 + 1));
        data_in_valid = 1'b0;
        repeat (5) @(posedge sclk);
        @(negedge sclk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_tvalid_idle"}, {31'd0, m_tvalid}, 32'd0);
    endtask

    initial begin
        int k;
        rst_n         = 1'b0;
        start         = 1'b0;
        data_in_valid = 1'b0;
        data_in       = '0;
        repeat (3) @(posedge sclk);
        #1;
        check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_tlast", {31'd0, m_tlast}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_ign", {31'd0, start_ignored}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge sclk);
        #1;

        send_frame(1, RAMP, 1'b0);
        wait_done("ramp");
        check("ramp_no_ignore", 32'(ign_cnt), 32'd0);

        send_frame(1, EXTREME, 1'b0);
        wait_done("extreme");
        check("min_word", got_words[0], 32'h0000E000);
        check("max_word", got_words[1], 32'h00001FFF);

        rand_ready = 1'b1;
        send_frame(1, RAMP, 1'b0);
        wait_done("rand_ready");
        rand_ready = 1'b0;

        send_frame(3, RAMP, 1'b0);
        wait_done("sparse_valid");

        ign_cnt = 0;
        send_frame(1, RAMP, 1'b1);
        wait_done("mid_start");
        check("ignore_pulses", 32'(ign_cnt), 32'd1);

        send_frame(1, RAMP, 1'b0);
        k = 0;
        while (widx < 300 && k < 5000) begin
            @(posedge sclk);
            k++;
        end
        check("reach_word300", {31'd0, (widx >= 300)}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("abort_tdata", m_tdata, 32'd0);
        check("abort_tlast", {31'd0, m_tlast}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        data_in_valid = 1'b0;
        repeat (3) @(posedge sclk);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge sclk);
        @(negedge sclk);
        check("post_rst_words", 32'(widx), 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge sclk);
        #1;
        send_frame(1, RAMP, 1'b0);
        wait_done("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
